// File: rtl/vibration_conditioner.sv
// Vibration sensor front end: synchroniser, debounce/qualify FSM with refractory holdoff,
// saturating hit counter and per-window hit intensity.
module vibration_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned HOLDOFF_CYCLES  = 2500000,
   parameter int unsigned WINDOW_CYCLES   = 50000000,
   parameter bit          ACTIVE_HIGH     = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vib_in,
   input  logic        clr_count,
   output logic        hit_pulse,
   output logic [15:0] hit_count,
   output logic [3:0]  intensity,
   output logic        window_tick,
   output logic        busy
);

   localparam int unsigned QW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
   localparam int unsigned WW = $clog2(WINDOW_CYCLES);
   localparam logic INACTIVE = ACTIVE_HIGH ? 1'b0 : 1'b1;

   typedef enum logic [1:0] {IDLE, QUALIFY, HOLDOFF, REARM} state_t;

   logic          sync1, sync2, vib_s;
   state_t        state, state_next;
   logic [QW-1:0] qcnt, qcnt_next;
   logic [HW-1:0] hcnt, hcnt_next;
   logic          accept;
   logic [15:0]   count_next;
   logic [WW-1:0] wcnt;
   logic [3:0]    wacc;

   // Synchroniser idles at the inactive level so reset never looks like a press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= INACTIVE;
         sync2 <= INACTIVE;
      end else begin
         sync1 <= vib_in;
         sync2 <= sync1;
      end
   end

   assign vib_s = ACTIVE_HIGH ? sync2 : ~sync2;

   always_comb begin
      state_next = state;
      qcnt_next  = qcnt;
      hcnt_next  = hcnt;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (vib_s) begin
               state_next = QUALIFY;
               qcnt_next  = '0;
            end
         end
         QUALIFY: begin
            if (!vib_s) begin
               state_next = IDLE;
            end else if (qcnt == QW'(DEBOUNCE_CYCLES - 1)) begin
               accept     = 1'b1;
               state_next = HOLDOFF;
               hcnt_next  = '0;
            end else begin
               qcnt_next = qcnt + 1'b1;
            end
         end
         HOLDOFF: begin
            if (hcnt == HW'(HOLDOFF_CYCLES - 1)) state_next = REARM;
            else hcnt_next = hcnt + 1'b1;
         end
         REARM: begin
            if (!vib_s) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         qcnt      <= '0;
         hcnt      <= '0;
         hit_pulse <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_next;
         qcnt      <= qcnt_next;
         hcnt      <= hcnt_next;
         hit_pulse <= accept;
         busy      <= (state_next != IDLE);
      end
   end

   // A clear coinciding with a hit leaves the new hit counted.
   always_comb begin
      count_next = hit_count;
      if (clr_count) count_next = {15'd0, accept};
      else if (accept && hit_count != 16'hFFFF) count_next = hit_count + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) hit_count <= '0;
      else     hit_count <= count_next;
   end

   // A hit on the wrap edge belongs to the window that is just starting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wcnt        <= '0;
         wacc        <= '0;
         intensity   <= '0;
         window_tick <= 1'b0;
      end else begin
         window_tick <= 1'b0;
         if (wcnt == WW'(WINDOW_CYCLES - 1)) begin
            wcnt        <= '0;
            intensity   <= wacc;
            window_tick <= 1'b1;
            wacc        <= {3'd0, accept};
         end else begin
            wcnt <= wcnt + 1'b1;
            if (accept && wacc != 4'hF) wacc <= wacc + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_vibration_conditioner.sv
// Scoreboard bench for vibration_conditioner: a run-length reference model predicts hits,
// counts and window intensities; a monitor compares them against the DUT every cycle.
module tb_vibration_conditioner;

   localparam int unsigned D = 4;
   localparam int unsigned H = 8;
   localparam int unsigned W = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        vib_in = 1'b0;
   logic        clr_count = 1'b0;
   logic        hit_pulse, window_tick, busy;
   logic [15:0] hit_count;
   logic [3:0]  intensity;

   vibration_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .HOLDOFF_CYCLES(H),
      .WINDOW_CYCLES(W),
      .ACTIVE_HIGH(1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .vib_in(vib_in),
      .clr_count(clr_count),
      .hit_pulse(hit_pulse),
      .hit_count(hit_count),
      .intensity(intensity),
      .window_tick(window_tick),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned e;
      logic [15:0] v;
   } ev_t;

   typedef struct {
      logic        busy;
      logic [15:0] cnt;
   } cyc_t;

   ev_t         hit_q[$];
   ev_t         win_q[$];
   cyc_t        cyc_q[$];
   int unsigned tests = 0;
   int unsigned fails = 0;
   int unsigned cyc = 0;
   logic        sat_load = 1'b0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_hit_pulse"}, 16'(hit_pulse), 16'd0);
      check({tag, "_hit_count"}, hit_count, 16'd0);
      check({tag, "_intensity"}, 16'(intensity), 16'd0);
      check({tag, "_window_tick"}, 16'(window_tick), 16'd0);
      check({tag, "_busy"}, 16'(busy), 16'd0);
   endtask

   task automatic drive(input logic v, input logic c, input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(negedge clk);
         vib_in    = v;
         clr_count = c;
      end
   endtask

   // Reference model: a hit is D+1 consecutive active synchronised samples seen while armed;
   // after a hit the next H samples are ignored and the line must go inactive before re-arming.
   initial begin : model
      logic        s1, s2, s, hit, need_rel;
      int unsigned run, lock_left, wacc, n;
      logic [15:0] cnt;
      ev_t         ev;
      cyc_t        c;
      s1 = 1'b0; s2 = 1'b0; need_rel = 1'b0;
      run = 0; lock_left = 0; wacc = 0; n = 0; cnt = '0;
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            s1 = 1'b0; s2 = 1'b0; need_rel = 1'b0;
            run = 0; lock_left = 0; wacc = 0; n = 0; cnt = '0;
         end else begin
            s   = s2;
            s2  = s1;
            s1  = vib_in;
            hit = 1'b0;
            if (sat_load) cnt = 16'hFFFF;
            if (lock_left > 0) begin
               lock_left--;
            end else if (need_rel) begin
               if (!s) need_rel = 1'b0;
            end else if (s) begin
               run++;
               if (run == D + 1) begin
                  hit       = 1'b1;
                  run       = 0;
                  need_rel  = 1'b1;
                  lock_left = H;
               end
            end else begin
               run = 0;
            end
            if (clr_count) cnt = hit ? 16'd1 : 16'd0;
            else if (hit && cnt != 16'hFFFF) cnt = cnt + 16'd1;
            n++;
            if (n % W == 0) begin
               ev.e = cyc;
               ev.v = 16'(wacc);
               win_q.push_back(ev);
               wacc = hit ? 1 : 0;
            end else if (hit && wacc < 15) begin
               wacc++;
            end
            if (hit) begin
               ev.e = cyc;
               ev.v = cnt;
               hit_q.push_back(ev);
            end
            c.busy = (run > 0) || need_rel;
            c.cnt  = cnt;
            cyc_q.push_back(c);
         end
      end
   end

   initial begin : monitor
      cyc_t c;
      ev_t  ev;
      logic exp_hit, exp_win;
      forever begin
         @(negedge clk);
         if (rst) begin
            cyc_q.delete();
            hit_q.delete();
            win_q.delete();
         end else begin
            if (cyc_q.size() > 0) begin
               c = cyc_q.pop_front();
               check("busy", 16'(busy), 16'(c.busy));
               check("hit_count", hit_count, c.cnt);
            end
            exp_hit = (hit_q.size() > 0) && (hit_q[0].e == cyc);
            check("hit_pulse", 16'(hit_pulse), 16'(exp_hit));
            if (exp_hit) ev = hit_q.pop_front();
            exp_win = (win_q.size() > 0) && (win_q[0].e == cyc);
            check("window_tick", 16'(window_tick), 16'(exp_win));
            if (exp_win) begin
               ev = win_q.pop_front();
               check("intensity", 16'(intensity), ev.v);
            end
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: got no finish, expected finish within 30000 cycles");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic        v;
      int unsigned len;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      drive(0, 0, 5);

      // held press, short press, bounce
      drive(1, 0, 20); drive(0, 0, 5);
      drive(1, 0, 3);  drive(0, 0, 8);
      repeat (20) begin drive(1, 0, 1); drive(0, 0, 1); end
      drive(0, 0, 6);

      // press during holdoff is ignored; press after holdoff and release counts
      drive(1, 0, 7); drive(0, 0, 4); drive(1, 0, 6); drive(0, 0, 4);
      drive(1, 0, 8); drive(0, 0, 12);

      // several hits, then windows with none
      repeat (4) begin drive(1, 0, 7); drive(0, 0, 10); end
      drive(0, 0, 140);

      // clear on the same edge as a hit
      drive(1, 0, 6); drive(1, 1, 1); drive(1, 0, 3); drive(0, 0, 12);

      // saturation at 16'hFFFF
      @(negedge clk);
      force dut.hit_count = 16'hFFFF;
      sat_load = 1'b1;
      @(posedge clk);
      #1;
      release dut.hit_count;
      sat_load = 1'b0;
      drive(1, 0, 8); drive(0, 0, 12);
      drive(0, 1, 1); drive(0, 0, 4);

      // reset while in holdoff
      drive(1, 0, 9);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_zero("midrst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      drive(1, 0, 10); drive(0, 0, 12);

      // randomized presses, bounces and clears
      repeat (150) begin
         v   = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 14);
         for (int unsigned i = 0; i < len; i++)
            drive(v, 1'($urandom_range(0, 29) == 0), 1);
      end
      drive(0, 0, 20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
